// File: rtl/us_cmd_builder.sv
// rtl/us_cmd_builder.sv - upstream command builder: merges RX completions and 32-bit writes into the command FIFO
// Optional counters are enabled by defining US_CMD_BUILDER_STATS_EN.
module us_cmd_builder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_req_vld_i,
  input  logic         rx_req_has_data_i,
  input  logic [2:0]   rx_tc_i,
  input  logic         rx_td_i,
  input  logic         rx_ep_i,
  input  logic [1:0]   rx_attr_i,
  input  logic [9:0]   rx_len_i,
  input  logic [15:0]  rx_rid_i,
  input  logic [7:0]   rx_tag_i,
  input  logic [7:0]   rx_be_i,
  input  logic [5:0]   rx_addr_i,
  output logic         rx_busy_o,
  input  logic         up_wr_req_i,
  input  logic [31:0]  up_wr_addr_i,
  input  logic [31:0]  up_wr_data_i,
  output logic         up_wr_ack_o,
  output logic         us_cmd_fifo_wr_en_o,
  output logic [127:0] us_cmd_fifo_din_o,
  input  logic         us_cmd_fifo_full_i,
  output logic [15:0]  cpl_cnt_o,
  output logic [15:0]  wr_cnt_o,
  output logic [15:0]  stall_cnt_o
);

  localparam logic [1:0] US_CMD_CPL_TYPE  = 2'b01;
  localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;
  localparam logic [1:0] US_CMD_WR32_TYPE = 2'b11;

  localparam logic LG_RX = 1'b0;
  localparam logic LG_WR = 1'b1;

  typedef enum logic {UP_IDLE, UP_BLANK} up_state_e;

  up_state_e   up_state_q, up_state_d;
  logic        rx_vld_q, rx_vld_d;
  logic [63:0] rx_word_q, rx_word_d;
  logic        last_grant_q, last_grant_d;

  logic rx_pend, wr_pend, grant_rx, grant_wr, fifo_wr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_state_q   <= UP_IDLE;
      rx_vld_q     <= 1'b0;
      last_grant_q <= LG_WR;
    end else begin
      up_state_q   <= up_state_d;
      rx_vld_q     <= rx_vld_d;
      last_grant_q <= last_grant_d;
    end
    rx_word_q <= rx_word_d;
  end

  // Write-path FSM next state: one blank cycle after every granted write
  always_comb begin
    up_state_d = up_state_q;
    case (up_state_q)
      UP_IDLE:  if (fifo_wr && grant_wr) up_state_d = UP_BLANK;
      UP_BLANK: up_state_d = UP_IDLE;
      default:  up_state_d = UP_IDLE;
    endcase
  end

  // Arbitration and FIFO write port
  always_comb begin
    rx_pend  = rx_vld_q;
    wr_pend  = up_wr_req_i && (up_state_q == UP_IDLE);
    grant_rx = rx_pend && (!wr_pend || (last_grant_q == LG_WR));
    grant_wr = wr_pend && !grant_rx;
    fifo_wr  = rst_n && (grant_rx || grant_wr) && !us_cmd_fifo_full_i;
    us_cmd_fifo_din_o = '0;
    if (rst_n && grant_rx)
      us_cmd_fifo_din_o = {64'd0, rx_word_q};
    else if (rst_n && grant_wr)
      us_cmd_fifo_din_o = {up_wr_data_i, up_wr_addr_i & 32'hFFFF_FFFC, US_CMD_WR32_TYPE, 62'd0};
    us_cmd_fifo_wr_en_o = fifo_wr;
    up_wr_ack_o         = fifo_wr && grant_wr;
    rx_busy_o           = rst_n && rx_vld_q;
  end

  // RX holding register and round-robin pointer
  always_comb begin
    rx_vld_d     = rx_vld_q;
    rx_word_d    = rx_word_q;
    last_grant_d = last_grant_q;
    if (fifo_wr && grant_rx) begin
      rx_vld_d = 1'b0;
    end else if (rx_req_vld_i && !rx_vld_q) begin
      rx_vld_d  = 1'b1;
      rx_word_d = {(rx_req_has_data_i ? US_CMD_CPLD_TYPE : US_CMD_CPL_TYPE), 7'd0,
                   rx_tc_i, rx_td_i, rx_ep_i, rx_attr_i, rx_len_i,
                   rx_rid_i, rx_tag_i, rx_be_i, rx_addr_i};
    end
    if (fifo_wr) last_grant_d = grant_wr ? LG_WR : LG_RX;
  end

`ifdef US_CMD_BUILDER_STATS_EN
  logic [15:0] cpl_cnt_q, cpl_cnt_d, wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    cpl_cnt_d   = cpl_cnt_q   + ((fifo_wr && grant_rx) ? 16'd1 : 16'd0);
    wr_cnt_d    = wr_cnt_q    + ((fifo_wr && grant_wr) ? 16'd1 : 16'd0);
    stall_cnt_d = stall_cnt_q + (((rx_pend || wr_pend) && us_cmd_fifo_full_i) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      cpl_cnt_q   <= cpl_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cpl_cnt_o   = rst_n ? cpl_cnt_q   : 16'd0;
  assign wr_cnt_o    = rst_n ? wr_cnt_q    : 16'd0;
  assign stall_cnt_o = rst_n ? stall_cnt_q : 16'd0;
`else
  assign cpl_cnt_o   = 16'd0;
  assign wr_cnt_o    = 16'd0;
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_us_cmd_builder.sv
// tb/tb_us_cmd_builder.sv - scoreboard bench for us_cmd_builder
module tb_us_cmd_builder;

  localparam logic [1:0] T_CPL  = 2'b01;
  localparam logic [1:0] T_CPLD = 2'b10;
  localparam logic [1:0] T_WR32 = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_req_vld = 1'b0, rx_has_data = 1'b0;
  logic [2:0]   rx_tc = '0;
  logic         rx_td = 1'b0, rx_ep = 1'b0;
  logic [1:0]   rx_attr = '0;
  logic [9:0]   rx_len = '0;
  logic [15:0]  rx_rid = '0;
  logic [7:0]   rx_tag = '0, rx_be = '0;
  logic [5:0]   rx_addr = '0;
  logic         rx_busy;
  logic         up_wr_req = 1'b0;
  logic [31:0]  up_wr_addr = '0, up_wr_data = '0;
  logic         up_wr_ack, wr_en;
  logic [127:0] din;
  logic         full = 1'b0;
  logic [15:0]  cpl_cnt, wr_cnt, stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  us_cmd_builder dut (
    .clk(clk), .rst_n(rst_n),
    .rx_req_vld_i(rx_req_vld), .rx_req_has_data_i(rx_has_data),
    .rx_tc_i(rx_tc), .rx_td_i(rx_td), .rx_ep_i(rx_ep), .rx_attr_i(rx_attr),
    .rx_len_i(rx_len), .rx_rid_i(rx_rid), .rx_tag_i(rx_tag), .rx_be_i(rx_be),
    .rx_addr_i(rx_addr), .rx_busy_o(rx_busy),
    .up_wr_req_i(up_wr_req), .up_wr_addr_i(up_wr_addr), .up_wr_data_i(up_wr_data),
    .up_wr_ack_o(up_wr_ack),
    .us_cmd_fifo_wr_en_o(wr_en), .us_cmd_fifo_din_o(din), .us_cmd_fifo_full_i(full),
    .cpl_cnt_o(cpl_cnt), .wr_cnt_o(wr_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] cpl_word(input logic hd, input logic [2:0] tc, input logic td,
      input logic ep, input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
      input logic [7:0] tag, input logic [7:0] be, input logic [5:0] addr);
    logic [127:0] w;
    w = '0;
    w[63:62] = hd ? T_CPLD : T_CPL;
    w[54:52] = tc;   w[51] = td;      w[50] = ep;     w[49:48] = attr;
    w[47:38] = len;  w[37:22] = rid;  w[21:14] = tag; w[13:6] = be;  w[5:0] = addr;
    return w;
  endfunction

  function automatic logic [127:0] wr_word(input logic [31:0] a, input logic [31:0] d);
    logic [127:0] w;
    w = '0;
    w[63:62]  = T_WR32;
    w[95:64]  = {a[31:2], 2'b00};
    w[127:96] = d;
    return w;
  endfunction

  // Drives one RX request; caller pulses vld for a single cycle.
  task automatic rx_set(input logic hd, input logic [2:0] tc, input logic td, input logic ep,
      input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
      input logic [7:0] tag, input logic [7:0] be, input logic [5:0] addr);
    rx_has_data = hd; rx_tc = tc; rx_td = td; rx_ep = ep; rx_attr = attr;
    rx_len = len; rx_rid = rid; rx_tag = tag; rx_be = be; rx_addr = addr;
    rx_req_vld = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_request(input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    up_wr_req = 1'b1; up_wr_addr = a; up_wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = up_wr_ack;
      tick();
    end
    up_wr_req = 1'b0;
    if (!got) check("wr_ack_timeout", got, 1);
  endtask

  // Scoreboard: every FIFO write must match the oldest expected command
  always @(negedge clk) begin
    logic [127:0] e;
    if (full) check("wr_while_full", wr_en, 0);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", din, 0);
      end else begin
        e = exp_q.pop_front();
        check("din", din, e);
        check("ack_with_wr", up_wr_ack, e[63:62] == T_WR32);
      end
    end else begin
      check("ack_idle", up_wr_ack, 0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_din", din, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_cpl_cnt", cpl_cnt, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Single CplD: written the cycle after the pulse, busy for one cycle
    rx_set(1, 3'd3, 0, 1, 2'd2, 10'd1, 16'hBEEF, 8'h2A, 8'h0F, 6'h15);
    exp_q.push_back(cpl_word(1, 3'd3, 0, 1, 2'd2, 10'd1, 16'hBEEF, 8'h2A, 8'h0F, 6'h15));
    @(negedge clk);
    check("t1_no_wr_same_cycle", wr_en, 0);
    check("t1_busy_before", rx_busy, 0);
    tick();
    rx_req_vld = 1'b0;
    @(negedge clk);
    check("t1_wr_next_cycle", wr_en, 1);
    check("t1_busy", rx_busy, 1);
    tick();
    @(negedge clk);
    check("t1_busy_clear", rx_busy, 0);

    // WR32: same-cycle write and ack, address low bits dropped
    tick();
    up_wr_req = 1'b1; up_wr_addr = 32'h0000_1003; up_wr_data = 32'hDEAD_BEEF;
    exp_q.push_back(wr_word(32'h0000_1003, 32'hDEAD_BEEF));
    @(negedge clk);
    check("t2_wr_en", wr_en, 1);
    check("t2_ack", up_wr_ack, 1);
    check("t2_addr", din[95:64], 32'h0000_1000);
    tick();
    up_wr_req = 1'b0;
    @(negedge clk);
    check("t2_no_second", wr_en, 0);
    tick();

    // Contention with last grant = WR: RX first, then WR32
    rx_set(0, 3'd1, 1, 0, 2'd1, 10'd4, 16'h1234, 8'h11, 8'hFF, 6'h3F);
    exp_q.push_back(cpl_word(0, 3'd1, 1, 0, 2'd1, 10'd4, 16'h1234, 8'h11, 8'hFF, 6'h3F));
    exp_q.push_back(wr_word(32'hCAFE_0006, 32'h0123_4567));
    tick();
    rx_req_vld = 1'b0;
    wr_request(32'hCAFE_0006, 32'h0123_4567);
    repeat (2) tick();

    // Lone Cpl leaves last grant = RX
    rx_set(0, 3'd7, 0, 0, 2'd0, 10'h3FF, 16'hFFFF, 8'hFF, 8'h00, 6'h00);
    exp_q.push_back(cpl_word(0, 3'd7, 0, 0, 2'd0, 10'h3FF, 16'hFFFF, 8'hFF, 8'h00, 6'h00));
    tick();
    rx_req_vld = 1'b0;
    repeat (3) tick();

    // Contention again: order alternates, WR32 first
    rx_set(1, 3'd2, 0, 1, 2'd3, 10'd16, 16'h0A0B, 8'h77, 8'hF0, 6'h2C);
    exp_q.push_back(wr_word(32'h8000_0001, 32'hA5A5_5A5A));
    exp_q.push_back(cpl_word(1, 3'd2, 0, 1, 2'd3, 10'd16, 16'h0A0B, 8'h77, 8'hF0, 6'h2C));
    tick();
    rx_req_vld = 1'b0;
    wr_request(32'h8000_0001, 32'hA5A5_5A5A);
    repeat (3) tick();
    check("t3_drained", exp_q.size(), 0);

    // Back-pressure: five full cycles with RX pending, second pulse ignored
    full = 1'b1;
    rx_set(1, 3'd0, 0, 0, 2'd0, 10'd2, 16'h0042, 8'h3C, 8'h0F, 6'h01);
    exp_q.push_back(cpl_word(1, 3'd0, 0, 0, 2'd0, 10'd2, 16'h0042, 8'h3C, 8'h0F, 6'h01));
    tick();
    rx_req_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) rx_set(0, 3'd5, 1, 1, 2'd1, 10'd9, 16'h9999, 8'h55, 8'hAA, 6'h09);
      @(negedge clk);
      check("t4_stall_no_wr", wr_en, 0);
      check("t4_busy_held", rx_busy, 1);
      tick();
      rx_req_vld = 1'b0;
    end
    full = 1'b0;
    @(negedge clk);
    check("t4_resume_wr", wr_en, 1);
    tick();
    @(negedge clk);
    check("t4_single_wr", wr_en, 0);
    check("t4_busy_clear", rx_busy, 0);
`ifdef US_CMD_BUILDER_STATS_EN
    check("cnt_cpl", cpl_cnt, 5);
    check("cnt_wr", wr_cnt, 3);
    check("cnt_stall", stall_cnt, 5);
`else
    check("cnt_cpl_off", cpl_cnt, 0);
    check("cnt_wr_off", wr_cnt, 0);
    check("cnt_stall_off", stall_cnt, 0);
`endif
    tick();

    // Reset with both sources pending drops everything
    full = 1'b1;
    rx_set(1, 3'd1, 0, 0, 2'd0, 10'd1, 16'h0001, 8'h01, 8'h01, 6'h01);
    tick();
    rx_req_vld = 1'b0;
    up_wr_req = 1'b1; up_wr_addr = 32'h4; up_wr_data = 32'h5;
    tick();
    rst_n = 1'b0;
    full  = 1'b0;
    @(negedge clk);
    check("t5_rst_no_wr", wr_en, 0);
    check("t5_rst_no_ack", up_wr_ack, 0);
    tick();
    rst_n = 1'b1;
    up_wr_req = 1'b0;
    @(negedge clk);
    check("t5_busy_after_rst", rx_busy, 0);
    check("t5_no_wr_after_rst", wr_en, 0);
    check("t5_stall_cnt_cleared", stall_cnt, 0);
    tick();

`ifdef US_CMD_BUILDER_STATS_EN
    // 65537 writes wrap the 16-bit counter back to 1
    for (int n = 0; n < 65537; n++) begin
      exp_q.push_back(wr_word(n, ~n));
      wr_request(n, ~n);
    end
    @(negedge clk);
    check("t6_wr_cnt_wrap", wr_cnt, 1);
    tick();
`endif

    repeat (2) tick();
    check("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/us_cmd_builder.md
US_CMD_BUILDER -- requirements
Module: us_cmd_builder

Interface
REQ-001 SHALL have: clk input 1, system clock; all logic on rising edge.
REQ-002 SHALL have: rst_n input 1, reset, synchronous, active-low.
REQ-003 SHALL have: rx_req_vld_i input 1, one-cycle pulse from the RX engine requesting a completion.
REQ-004 SHALL have: rx_req_has_data_i input 1, 1 = memory read (CplD), 0 = non-posted without data (Cpl).
REQ-005 SHALL have the following RX request fields as inputs, valid with rx_req_vld_i: rx_tc_i 3, rx_td_i 1, rx_ep_i 1, rx_attr_i 2, rx_len_i 10, rx_rid_i 16, rx_tag_i 8, rx_be_i 8, rx_addr_i 6.
REQ-006 SHALL have: rx_busy_o output 1, high while the RX holding register is occupied; the RX engine shall not pulse while it is high.
REQ-007 SHALL have: up_wr_req_i input 1, level request for an upstream 32-bit write; held until acknowledged.
REQ-008 SHALL have: up_wr_addr_i input 32 and up_wr_data_i input 32, stable while up_wr_req_i is high.
REQ-009 SHALL have: up_wr_ack_o output 1, one-cycle pulse when the write command enters the FIFO.
REQ-010 SHALL have: us_cmd_fifo_wr_en_o output 1 and us_cmd_fifo_din_o output 128, the upstream command FIFO write port.
REQ-011 SHALL have: us_cmd_fifo_full_i input 1, FIFO full flag.
REQ-012 SHALL have, when enabled: cpl_cnt_o output 16, wr_cnt_o output 16, stall_cnt_o output 16 (see Configuration).

Function
REQ-013 SHALL capture all RX fields into a holding register on rx_req_vld_i while rx_busy_o is low; rx_busy_o SHALL equal the register-valid flag.
REQ-014 SHALL ignore rx_req_vld_i while rx_busy_o is high; no capture and no overwrite.
REQ-015 SHALL pack the completion word as: [63:62] US_CMD_CPLD_TYPE if has_data else US_CMD_CPL_TYPE; [61:55]=0; [54:52] tc; [51] td; [50] ep; [49:48] attr; [47:38] len; [37:22] rid; [21:14] tag; [13:6] be; [5:0] addr; [127:64]=0.
REQ-016 SHALL pack the write word as: [63:62] US_CMD_WR32_TYPE; [61:0]=0; [95:64] up_wr_addr_i with bits [1:0] forced to 0; [127:96] up_wr_data_i.
REQ-017 SHALL use only the type encodings from the shared parameter include.
REQ-018 SHALL drive us_cmd_fifo_wr_en_o combinationally as (a source is granted) AND NOT us_cmd_fifo_full_i, and SHALL never assert it while full is high.
REQ-019 SHALL drive us_cmd_fifo_din_o from the granted source, and SHALL drive it to 0 when no source is granted.
REQ-020 SHALL grant at most one command per cycle, using round-robin when both sources are pending; last_grant SHALL update only on an actual write.
REQ-021 SHALL handle the write path with a two-state FSM: UP_IDLE->UP_BLANK on a granted write; UP_BLANK->UP_IDLE unconditionally after one cycle. up_wr_req_i SHALL be ignored in UP_BLANK.
REQ-022 SHALL make the write source pending only when up_wr_req_i is high and the FSM is in UP_IDLE.
REQ-023 SHALL assert up_wr_ack_o in the same cycle as the WR32 write.
REQ-024 SHALL clear the RX holding register on the edge ending its write cycle.
REQ-025 SHALL have the following latency: RX pulse at cycle N gives a FIFO write at the earliest in cycle N+1; a write request seen at cycle N is written at the earliest in cycle N.
REQ-026 SHALL hold all pending state unchanged while us_cmd_fifo_full_i is high; full deasserting SHALL resume the grant in that same cycle.

Reset
REQ-027 SHALL, on reset, clear the RX holding valid flag, set the FSM to UP_IDLE, set last_grant to WR (RX wins first contention), and clear all counters.
REQ-028 SHALL hold all outputs at 0 during reset; reset mid-operation SHALL drop any pending command with no FIFO write and no ack.

Configuration
REQ-029 SHALL, with macro US_CMD_BUILDER_STATS_EN defined, implement three 16-bit wrapping counters: cpl_cnt_o counts CPL/CPLD writes, wr_cnt_o counts WR32 writes, and stall_cnt_o counts cycles with a pending source and full high. Counters SHALL wrap 0xFFFF->0x0000.
REQ-030 SHALL, without the macro, tie all three counter outputs to 0 and instantiate no counter flops; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover: an RX pulse with has_data=1, tag=0x2A, len=1, full=0 -> wr_en in the next cycle, din[63:62]=US_CMD_CPLD_TYPE, din[21:14]=0x2A, rx_busy_o high for exactly 1 cycle.
REQ-032 SHALL cover: up_wr_req with addr=0x1003, data=0xDEADBEEF -> same-cycle wr_en and ack, din[95:64]=0x00001000, din[127:96]=0xDEADBEEF; req dropped the next cycle -> no second write.
REQ-033 SHALL cover: both sources pending after reset -> RX written first, WR32 next cycle; repeat with both pending -> order alternates.
REQ-034 SHALL cover: full=1 for 5 cycles with an RX pending -> no wr_en, rx_busy_o held, a second RX pulse ignored; full=0 -> exactly one write, and stall_cnt_o=5 when enabled.
REQ-035 SHALL cover: rst_n low while both sources are pending -> no wr_en, no ack, rx_busy_o=0 in the cycle after reset.
REQ-036 SHALL cover: with stats enabled, 65537 WR32 commands -> wr_cnt_o=1.
